// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - byte-stream operand packer and sequencer for matrix_multiplication
//
// Collects 18 signed bytes, packs bytes 0-8 into A and bytes 9-17 into B
// (row-major, byte n at bits n*8 +: 8), pulses mult_reset, runs the
// multiplier until done or a watchdog expiry, then pulses job_done.
//
// Ports:
//   Clock       system clock, rising edge
//   reset       synchronous active-high reset
//   in_data     operand byte (two's complement)
//   in_valid    in_data valid
//   in_ready    loader accepts a byte this cycle
//   A, B        packed 3x3 operand matrices to the multiplier
//   mult_reset  one-cycle clear pulse to the multiplier
//   Enable      multiplier enable
//   done        multiplier completion flag
//   job_done    one-cycle pulse, result on C is valid
//   error       sticky timeout flag, cleared only by reset
//   byte_count  bytes accepted in the current job, 0-18

module matrix_loader #(
   parameter int TIMEOUT = 64
) (
   input  logic        Clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [71:0] A,
   output logic [71:0] B,
   output logic        mult_reset,
   output logic        Enable,
   input  logic        done,
   output logic        job_done,
   output logic        error,
   output logic [4:0]  byte_count
);

   typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_RUN, S_FINISH} state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t       state;
   // A occupies the low 72 bits and B the high 72 bits, so byte n of the
   // stream always lands at bit n*8 regardless of which matrix it belongs to.
   logic [143:0] operands;
   logic [7:0]   watchdog;

   assign A = operands[71:0];
   assign B = operands[143:72];

   // Outputs are registered and updated on the same edge as the state, so
   // each one equals the decode of the state it accompanies.
   always_ff @(posedge Clock) begin
      if (reset) begin
         state      <= S_LOAD;
         operands   <= '0;
         watchdog   <= '0;
         byte_count <= '0;
         in_ready   <= 1'b1;
         mult_reset <= 1'b0;
         Enable     <= 1'b0;
         job_done   <= 1'b0;
         error      <= 1'b0;
      end else begin
         mult_reset <= 1'b0;
         job_done   <= 1'b0;
         case (state)
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  operands[{byte_count, 3'b000} +: 8] <= in_data;
                  byte_count <= byte_count + 5'd1;
                  if (byte_count == 5'd17) begin
                     state      <= S_CLEAR;
                     in_ready   <= 1'b0;
                     mult_reset <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               state      <= S_RUN;
               byte_count <= '0;
               watchdog   <= '0;
               Enable     <= 1'b1;
            end
            S_RUN: begin
               // done wins over an expiry landing in the same cycle
               if (done) begin
                  state    <= S_FINISH;
                  Enable   <= 1'b0;
                  job_done <= 1'b1;
               end else if (watchdog == WD_LAST) begin
                  state    <= S_FINISH;
                  Enable   <= 1'b0;
                  job_done <= 1'b1;
                  error    <= 1'b1;
               end else begin
                  watchdog <= watchdog + 8'd1;
               end
            end
            S_FINISH: begin
               state    <= S_LOAD;
               in_ready <= 1'b1;
            end
            default: begin
               state    <= S_LOAD;
               in_ready <= 1'b1;
               Enable   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - self-checking bench for matrix_loader with a behavioural multiplier

module tb_matrix_loader;

   localparam int TO = 64;

   logic        Clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [71:0] A, B;
   logic        mult_reset, Enable, job_done, error;
   logic        done = 1'b0;
   logic [4:0]  byte_count;

   int checks = 0;
   int failures = 0;

   matrix_loader #(.TIMEOUT(TO)) dut (
      .Clock(Clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .A(A), .B(B), .mult_reset(mult_reset),
      .Enable(Enable), .done(done), .job_done(job_done), .error(error),
      .byte_count(byte_count)
   );

   always #5 Clock = ~Clock;

   // Event logs. Times are cycle numbers: a transfer is numbered by the edge
   // that takes it; a level seen after edge n belongs to cycle n+1.
   int          ecnt = 0;
   int          xfer_t[$];
   int          jd_t[$];
   logic [71:0] jd_a[$];
   logic [71:0] jd_b[$];
   logic        jd_err[$];
   int          jd_en[$];
   int          mr_t[$];
   int          mr_bc[$];
   int          en_t[$];
   logic        en_prev = 1'b0;
   int          en_run = 0;
   bit          done_en = 1'b1;

   always @(posedge Clock) begin
      ecnt++;
      if (in_valid && in_ready && !reset) xfer_t.push_back(ecnt);
   end

   // Logging plus the multiplier model: done on the 29th consecutive Enable cycle.
   always @(negedge Clock) begin
      if (job_done) begin
         jd_t.push_back(ecnt + 1);
         jd_a.push_back(A);
         jd_b.push_back(B);
         jd_err.push_back(error);
         jd_en.push_back(en_run);
      end
      if (mult_reset) begin
         mr_t.push_back(ecnt + 1);
         mr_bc.push_back(int'(byte_count));
      end
      if (Enable && !en_prev) en_t.push_back(ecnt + 1);
      en_prev = Enable;
      if (Enable) begin
         en_run++;
         done = done_en && (en_run == 29);
      end else begin
         en_run = 0;
         done = 1'b0;
      end
   end

   function automatic logic [71:0] pack9(input logic [7:0] b[18], input int base);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) r[i*8 +: 8] = b[base + i];
      return r;
   endfunction

   function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
      logic [71:0] c;
      int s;
      c = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
               s += int'($signed(a[(i*3+k)*8 +: 8])) * int'($signed(b[(k*3+j)*8 +: 8]));
            c[(i*3+j)*8 +: 8] = s[7:0];
         end
      return c;
   endfunction

   task automatic clear_logs();
      @(posedge Clock);
      xfer_t.delete(); jd_t.delete(); jd_a.delete(); jd_b.delete();
      jd_err.delete(); jd_en.delete(); mr_t.delete(); mr_bc.delete(); en_t.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge Clock);
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(negedge Clock);
      reset = 1'b0;
      #1;
   endtask

   task automatic rand_job(output logic [7:0] b[18]);
      for (int i = 0; i < 18; i++) b[i] = 8'($urandom);
   endtask

   // Offers bytes first..n-1; returns just after the edge taking the last one.
   task automatic drive_bytes(input logic [7:0] b[18], input int first, input int n, input bit toggle);
      int sent = first;
      int k = 0;
      while (sent < n && k < 400) begin
         @(negedge Clock);
         in_valid = toggle ? (k % 2 == 0) : 1'b1;
         in_data = b[sent];
         if (in_valid && in_ready) sent++;
         k++;
      end
      @(posedge Clock);
      checks++;
      if (sent != n) begin
         failures++;
         $display("FAIL drive_bytes: sent %0d bytes, required %0d", sent, n);
      end
   endtask

   task automatic wait_jobs(input int n, input int budget);
      int k = 0;
      while (jd_t.size() < n && k < budget) begin
         @(negedge Clock);
         #1;
         k++;
      end
      checks++;
      if (jd_t.size() < n) begin
         failures++;
         $display("FAIL wait_jobs: saw %0d job_done pulses, required %0d", jd_t.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      checks += 9;
      if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (A !== 72'h0)         begin failures++; $display("FAIL reset_A: got %h want 0", A); end
      if (B !== 72'h0)         begin failures++; $display("FAIL reset_B: got %h want 0", B); end
      if (byte_count !== 5'd0) begin failures++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
      if (mult_reset !== 1'b0) begin failures++; $display("FAIL reset_mult_reset: got %b want 0", mult_reset); end
      if (Enable !== 1'b0)     begin failures++; $display("FAIL reset_Enable: got %b want 0", Enable); end
      if (job_done !== 1'b0)   begin failures++; $display("FAIL reset_job_done: got %b want 0", job_done); end
      if (error !== 1'b0)      begin failures++; $display("FAIL reset_error: got %b want 0", error); end
      @(negedge Clock);
      if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready_hold: got %b want 1", in_ready); end
   endtask

   task automatic test_identity();
      logic [7:0] b[18];
      logic [71:0] ea;
      for (int i = 0; i < 9; i++) b[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      for (int i = 0; i < 9; i++) b[9 + i] = 8'(i + 1);
      ea = pack9(b, 0);
      clear_logs();
      drive_bytes(b, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      checks++;
      if (A !== 72'h01_00_00_00_01_00_00_00_01 || A !== ea) begin
         failures++; $display("FAIL identity_A_packed: got %h want %h", A, ea);
      end
      wait_jobs(1, 200);
      if (jd_t.size() >= 1 && en_t.size() >= 1 && xfer_t.size() >= 18) begin
         checks += 5;
         if (en_t[0] - xfer_t[0] != 19) begin failures++; $display("FAIL identity_enable_delay: got %0d want 19", en_t[0] - xfer_t[0]); end
         if (jd_t[0] - xfer_t[0] != 48) begin failures++; $display("FAIL identity_job_done_cycle: got %0d want 49", jd_t[0] - xfer_t[0] + 1); end
         if (matmul(jd_a[0], jd_b[0]) !== 72'h09_08_07_06_05_04_03_02_01) begin
            failures++; $display("FAIL identity_C: got %h want 090807060504030201", matmul(jd_a[0], jd_b[0]));
         end
         if (jd_b[0] !== pack9(b, 9)) begin failures++; $display("FAIL identity_B: got %h want %h", jd_b[0], pack9(b, 9)); end
         if (jd_err[0] !== 1'b0) begin failures++; $display("FAIL identity_error: got %b want 0", jd_err[0]); end
      end
   endtask

   task automatic test_signed_wrap();
      logic [7:0] b[18];
      for (int i = 0; i < 18; i++) b[i] = (i < 9) ? 8'h7F : 8'h02;
      clear_logs();
      drive_bytes(b, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      wait_jobs(1, 200);
      if (jd_t.size() >= 1) begin
         checks += 2;
         if (matmul(jd_a[0], jd_b[0]) !== {9{8'hFA}}) begin
            failures++; $display("FAIL signed_wrap_C: got %h want %h", matmul(jd_a[0], jd_b[0]), {9{8'hFA}});
         end
         if (jd_err[0] !== 1'b0) begin failures++; $display("FAIL signed_wrap_error: got %b want 0", jd_err[0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] b[18];
      rand_job(b);
      clear_logs();
      drive_bytes(b, 0, 18, 1'b1);
      @(negedge Clock);
      in_valid = 1'b1;
      in_data = 8'hAA;
      wait_jobs(1, 200);
      in_valid = 1'b0;
      repeat (3) @(negedge Clock);
      checks += 5;
      if (xfer_t.size() != 18) begin failures++; $display("FAIL backpressure_transfers: got %0d want 18", xfer_t.size()); end
      if (mr_bc.size() < 1 || mr_bc[0] != 18) begin
         failures++; $display("FAIL backpressure_byte_count: got %0d want 18", (mr_bc.size() > 0) ? mr_bc[0] : -1);
      end
      if (byte_count !== 5'd0) begin failures++; $display("FAIL backpressure_count_after: got %0d want 0", byte_count); end
      if (jd_t.size() >= 1) begin
         if (jd_a[0] !== pack9(b, 0) || jd_b[0] !== pack9(b, 9)) begin
            failures++; $display("FAIL backpressure_operands: got %h_%h want %h_%h", jd_b[0], jd_a[0], pack9(b, 9), pack9(b, 0));
         end
         if (matmul(jd_a[0], jd_b[0]) !== matmul(pack9(b, 0), pack9(b, 9))) begin
            failures++; $display("FAIL backpressure_C: got %h want %h", matmul(jd_a[0], jd_b[0]), matmul(pack9(b, 0), pack9(b, 9)));
         end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b[18];
      logic [7:0] b2[18];
      rand_job(b);
      rand_job(b2);
      clear_logs();
      done_en = 1'b0;
      drive_bytes(b, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      wait_jobs(1, 300);
      done_en = 1'b1;
      @(negedge Clock);
      #1;
      checks += 3;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL timeout_back_to_load: in_ready got %b want 1", in_ready); end
      if (jd_t.size() >= 1) begin
         if (jd_en[0] != TO) begin failures++; $display("FAIL timeout_enable_cycles: got %0d want %0d", jd_en[0], TO); end
         if (jd_err[0] !== 1'b1) begin failures++; $display("FAIL timeout_error_set: got %b want 1", jd_err[0]); end
      end
      drive_bytes(b2, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      wait_jobs(2, 200);
      if (jd_t.size() >= 2) begin
         checks += 3;
         if (jd_err[1] !== 1'b1) begin failures++; $display("FAIL timeout_error_sticky: got %b want 1", jd_err[1]); end
         if (jd_en[1] != 29) begin failures++; $display("FAIL timeout_next_enable: got %0d want 29", jd_en[1]); end
         if (matmul(jd_a[1], jd_b[1]) !== matmul(pack9(b2, 0), pack9(b2, 9))) begin
            failures++; $display("FAIL timeout_next_C: got %h want %h", matmul(jd_a[1], jd_b[1]), matmul(pack9(b2, 0), pack9(b2, 9)));
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b[18];
      logic [7:0] b2[18];
      rand_job(b);
      rand_job(b2);
      clear_logs();
      drive_bytes(b, 0, 10, 1'b0);
      do_reset(1);
      checks += 3;
      if (byte_count !== 5'd0) begin failures++; $display("FAIL midload_byte_count: got %0d want 0", byte_count); end
      if (A !== 72'h0) begin failures++; $display("FAIL midload_A_cleared: got %h want 0", A); end
      if (error !== 1'b0) begin failures++; $display("FAIL midload_error_cleared: got %b want 0", error); end
      clear_logs();
      drive_bytes(b2, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      wait_jobs(1, 200);
      if (jd_t.size() >= 1) begin
         checks += 2;
         if (jd_a[0] !== pack9(b2, 0) || jd_b[0] !== pack9(b2, 9)) begin
            failures++; $display("FAIL midload_operands: got %h_%h want %h_%h", jd_b[0], jd_a[0], pack9(b2, 9), pack9(b2, 0));
         end
         if (jd_err[0] !== 1'b0) begin failures++; $display("FAIL midload_error: got %b want 0", jd_err[0]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[18];
      logic [7:0] b2[18];
      rand_job(b);
      rand_job(b2);
      clear_logs();
      drive_bytes(b, 0, 18, 1'b0);
      drive_bytes(b2, 0, 18, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      wait_jobs(2, 200);
      checks++;
      if (mr_t.size() != 2 || en_t.size() != 2) begin
         failures++; $display("FAIL b2b_pulse_counts: got mult_reset=%0d enable=%0d want 2 2", mr_t.size(), en_t.size());
      end else begin
         checks += 2;
         if (en_t[0] != mr_t[0] + 1) begin failures++; $display("FAIL b2b_order_job1: enable %0d mult_reset %0d", en_t[0], mr_t[0]); end
         if (en_t[1] != mr_t[1] + 1) begin failures++; $display("FAIL b2b_order_job2: enable %0d mult_reset %0d", en_t[1], mr_t[1]); end
      end
      if (jd_t.size() >= 2) begin
         checks += 3;
         if (jd_t[1] - jd_t[0] != 49) begin failures++; $display("FAIL b2b_spacing: got %0d want 49", jd_t[1] - jd_t[0]); end
         if (matmul(jd_a[0], jd_b[0]) !== matmul(pack9(b, 0), pack9(b, 9))) begin
            failures++; $display("FAIL b2b_C_job1: got %h want %h", matmul(jd_a[0], jd_b[0]), matmul(pack9(b, 0), pack9(b, 9)));
         end
         if (jd_a[1] !== pack9(b2, 0) || jd_b[1] !== pack9(b2, 9)) begin
            failures++; $display("FAIL b2b_operands_job2: got %h_%h want %h_%h", jd_b[1], jd_a[1], pack9(b2, 9), pack9(b2, 0));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_identity();
      test_signed_wrap();
      test_backpressure();
      test_timeout();
      test_reset_mid_load();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
